// File: rtl/alu_seq.sv
// alu_seq: SAP-3 accumulator ALU with single-cycle ops plus multi-cycle shift-add MUL and restoring DIV.
// Define ALU_SEQ_DIV_EN to build the divider (opcode 0x13); when undefined DIV is a no-op and E reads 0.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] bus,
    input  logic             a_we,
    input  logic             tmp_we,
    input  logic             flags_we,
    input  logic             a_store,
    input  logic             a_restore,
    output logic             busy,
    output logic             done,
    output logic [7:0]       flags,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_P = 2;
    localparam int F_S = 3;
    localparam int F_V = 4;
    localparam int F_E = 5;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_ADC = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_SBB = 5'h03;
    localparam logic [4:0] OP_ANA = 5'h04;
    localparam logic [4:0] OP_XRA = 5'h05;
    localparam logic [4:0] OP_ORA = 5'h06;
    localparam logic [4:0] OP_CMP = 5'h07;
    localparam logic [4:0] OP_RLC = 5'h08;
    localparam logic [4:0] OP_RRC = 5'h09;
    localparam logic [4:0] OP_RAL = 5'h0A;
    localparam logic [4:0] OP_RAR = 5'h0B;
    localparam logic [4:0] OP_CMA = 5'h0D;
    localparam logic [4:0] OP_STC = 5'h0E;
    localparam logic [4:0] OP_CMC = 5'h0F;
    localparam logic [4:0] OP_INR = 5'h10;
    localparam logic [4:0] OP_DCR = 5'h11;
    localparam logic [4:0] OP_MUL = 5'h12;
    localparam logic [4:0] OP_DIV = 5'h13;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_SEQ_DIV_EN
    localparam logic [5:0] FLAG_MASK = 6'h3F;
`else
    localparam logic [5:0] FLAG_MASK = 6'h1F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] tmp_reg, tmp_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] save_reg, save_next;
    logic [5:0]       flag_reg, flag_next;
    logic [WIDTH-1:0] w_hi_reg, w_hi_next;
    logic [WIDTH-1:0] w_lo_reg, w_lo_next;
    logic [WIDTH-1:0] w_b_reg, w_b_next;

    logic             accept;
    logic             start_mc;
    logic             start_div;
    logic             div_zero;
    logic             div_mode;
    logic [WIDTH-1:0] op_res;
    logic             op_acc_wr;
    logic [5:0]       op_flags;
    logic             op_flag_wr;
    logic [WIDTH:0]   arith;
    logic [5:0]       bus_flags;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [5:0]       fin_flags;

    // bus may be narrower than the flag field when WIDTH < 6
    generate
        if (WIDTH >= 6) begin : g_bus_wide
            assign bus_flags = bus[5:0] & FLAG_MASK;
        end else begin : g_bus_narrow
            assign bus_flags = {{(6-WIDTH){1'b0}}, bus} & FLAG_MASK;
        end
    endgenerate

    function automatic logic [5:0] set_zps(input logic [WIDTH-1:0] r, input logic [5:0] f);
        logic [5:0] t;
        t      = f;
        t[F_Z] = (r == '0);
        t[F_P] = ~^r;
        t[F_S] = r[MSB];
        return t;
    endfunction

    assign accept   = cs && (state_reg != ST_RUN);
    assign start_mc = (accept && (op == OP_MUL)) || start_div;

`ifdef ALU_SEQ_DIV_EN
    logic div_mode_reg;

    assign start_div = accept && (op == OP_DIV) && (tmp_reg != '0);
    assign div_zero  = accept && (op == OP_DIV) && (tmp_reg == '0);
    assign div_mode  = div_mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_mode_reg <= 1'b0;
        end else if (start_mc) begin
            div_mode_reg <= start_div;
        end
    end
`else
    assign start_div = 1'b0;
    assign div_zero  = 1'b0;
    assign div_mode  = 1'b0;
`endif

    // One iteration of the multi-cycle engine; w_hi/w_lo hold the partial {hi, lo} pair.
    always_comb begin
        logic [WIDTH:0] mul_sum;
        mul_sum = {1'b0, w_hi_reg} + (w_lo_reg[0] ? {1'b0, w_b_reg} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], w_lo_reg[MSB:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_mode) begin
            logic [WIDTH:0] shifted;
            shifted = {w_hi_reg, w_lo_reg[MSB]};
            if (shifted >= {1'b0, w_b_reg}) begin
                step_hi = shifted[MSB:0] - w_b_reg;
                step_lo = {w_lo_reg[MSB-1:0], 1'b1};
            end else begin
                step_hi = shifted[MSB:0];
                step_lo = {w_lo_reg[MSB-1:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        fin_flags = flag_reg;
        if (div_mode) begin
            fin_flags      = set_zps(step_lo, 6'h00);
        end else begin
            fin_flags[F_Z] = ({step_hi, step_lo} == '0);
            fin_flags[F_C] = (step_hi != '0);
            fin_flags[F_V] = (step_hi != '0);
            fin_flags[F_S] = step_hi[MSB];
            fin_flags[F_P] = ~^step_lo;
        end
    end

    // Single-cycle op decode; multi-cycle ops only start the engine.
    always_comb begin
        op_res     = acc_reg;
        op_acc_wr  = 1'b0;
        op_flags   = flag_reg;
        op_flag_wr = 1'b0;
        arith      = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                arith      = {1'b0, acc_reg} + {1'b0, tmp_reg}
                           + {{WIDTH{1'b0}}, (op == OP_ADC) & flag_reg[F_C]};
                op_res     = arith[MSB:0];
                op_acc_wr  = 1'b1;
                op_flag_wr = 1'b1;
                op_flags   = set_zps(arith[MSB:0], flag_reg);
                op_flags[F_C] = arith[WIDTH];
                op_flags[F_V] = (acc_reg[MSB] == tmp_reg[MSB]) && (arith[MSB] != acc_reg[MSB]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                arith      = {1'b0, acc_reg} - {1'b0, tmp_reg}
                           - {{WIDTH{1'b0}}, (op == OP_SBB) & flag_reg[F_C]};
                op_res     = arith[MSB:0];
                op_acc_wr  = (op != OP_CMP);
                op_flag_wr = 1'b1;
                op_flags   = set_zps(arith[MSB:0], flag_reg);
                op_flags[F_C] = arith[WIDTH];
                op_flags[F_V] = (acc_reg[MSB] != tmp_reg[MSB]) && (arith[MSB] != acc_reg[MSB]);
            end
            OP_ANA, OP_XRA, OP_ORA: begin
                if (op == OP_ANA)      op_res = acc_reg & tmp_reg;
                else if (op == OP_XRA) op_res = acc_reg ^ tmp_reg;
                else                   op_res = acc_reg | tmp_reg;
                op_acc_wr  = 1'b1;
                op_flag_wr = 1'b1;
                op_flags   = set_zps(op_res, flag_reg);
                op_flags[F_C] = 1'b0;
                op_flags[F_V] = 1'b0;
            end
            OP_RLC, OP_RAL: begin
                op_res     = {acc_reg[MSB-1:0], (op == OP_RLC) ? acc_reg[MSB] : flag_reg[F_C]};
                op_acc_wr  = 1'b1;
                op_flag_wr = 1'b1;
                op_flags[F_C] = acc_reg[MSB];
            end
            OP_RRC, OP_RAR: begin
                op_res     = {(op == OP_RRC) ? acc_reg[0] : flag_reg[F_C], acc_reg[MSB:1]};
                op_acc_wr  = 1'b1;
                op_flag_wr = 1'b1;
                op_flags[F_C] = acc_reg[0];
            end
            OP_CMA: begin
                op_res    = ~acc_reg;
                op_acc_wr = 1'b1;
            end
            OP_STC, OP_CMC: begin
                op_flag_wr = 1'b1;
                op_flags[F_C] = (op == OP_STC) ? 1'b1 : ~flag_reg[F_C];
            end
            OP_INR, OP_DCR: begin
                op_res     = (op == OP_INR) ? acc_reg + WIDTH'(1) : acc_reg - WIDTH'(1);
                op_acc_wr  = 1'b1;
                op_flag_wr = 1'b1;
                op_flags   = set_zps(op_res, flag_reg);
                op_flags[F_V] = (op == OP_INR) ? (acc_reg == MAX_POS) : (acc_reg == MIN_NEG);
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                if (tmp_reg == '0) begin
                    op_flag_wr = 1'b1;
                    op_flags[F_E] = 1'b1;
                    op_flags[F_C] = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Next-state and register-load logic; in RUN every programmer-visible input is ignored.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        tmp_next   = tmp_reg;
        hi_next    = hi_reg;
        save_next  = save_reg;
        flag_next  = flag_reg;
        w_hi_next  = w_hi_reg;
        w_lo_next  = w_lo_reg;
        w_b_next   = w_b_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                busy      = 1'b1;
                w_hi_next = step_hi;
                w_lo_next = step_lo;
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_DONE;
                    acc_next   = step_lo;
                    hi_next    = step_hi;
                    flag_next  = fin_flags;
                end
            end
            default: begin
                done       = (state_reg == ST_DONE);
                state_next = ST_IDLE;
                if (accept && op_acc_wr)  acc_next  = op_res;
                if (accept && op_flag_wr) flag_next = op_flags;
                if (start_mc) begin
                    state_next = ST_RUN;
                    cnt_next   = CW'(WIDTH);
                    w_hi_next  = '0;
                    w_lo_next  = acc_reg;
                    w_b_next   = tmp_reg;
                end else if (div_zero) begin
                    state_next = ST_DONE;
                end
                if (a_restore) acc_next  = save_reg;
                if (a_we)      acc_next  = bus;
                if (tmp_we)    tmp_next  = bus;
                if (a_store)   save_next = acc_reg;
                if (flags_we)  flag_next = bus_flags;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            tmp_reg   <= '0;
            hi_reg    <= '0;
            save_reg  <= '0;
            flag_reg  <= '0;
            w_hi_reg  <= '0;
            w_lo_reg  <= '0;
            w_b_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            tmp_reg   <= tmp_next;
            hi_reg    <= hi_next;
            save_reg  <= save_next;
            flag_reg  <= flag_next;
            w_hi_reg  <= w_hi_next;
            w_lo_reg  <= w_lo_next;
            w_b_reg   <= w_b_next;
        end
    end

    assign flags = {2'b00, flag_reg};
    assign out   = acc_reg;
    assign hi    = hi_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8); DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

    localparam int WIDTH = 8;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [7:0] E_BIT = 8'h20;
`else
    localparam logic [7:0] E_BIT = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cs = 1'b0;
    logic [4:0]       op = 5'h0;
    logic [WIDTH-1:0] bus = '0;
    logic             a_we = 1'b0;
    logic             tmp_we = 1'b0;
    logic             flags_we = 1'b0;
    logic             a_store = 1'b0;
    logic             a_restore = 1'b0;
    logic             busy;
    logic             done;
    logic [7:0]       flags;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .op        (op),
        .bus       (bus),
        .a_we      (a_we),
        .tmp_we    (tmp_we),
        .flags_we  (flags_we),
        .a_store   (a_store),
        .a_restore (a_restore),
        .busy      (busy),
        .done      (done),
        .flags     (flags),
        .out       (out),
        .hi        (hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [WIDTH-1:0] v);
        a_we = 1'b1; bus = v;
        tick();
        a_we = 1'b0;
    endtask

    task automatic load_t(input logic [WIDTH-1:0] v);
        tmp_we = 1'b1; bus = v;
        tick();
        tmp_we = 1'b0;
    endtask

    task automatic issue(input logic [4:0] opc);
        cs = 1'b1; op = opc;
        tick();
        cs = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        #12;
        check("reset_out", 16'(out), 16'h00);
        check("reset_hi", 16'(hi), 16'h00);
        check("reset_flags", 16'(flags), 16'h00);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        rst_n = 1'b1;

        load_a(8'hFF); load_t(8'h01); issue(5'h00);
        check("add_out", 16'(out), 16'h00);
        check("add_flags", 16'(flags), 16'h07);

        load_a(8'h10); load_t(8'h20); issue(5'h07);
        check("cmp_out", 16'(out), 16'h10);
        check("cmp_flags", 16'(flags), 16'h0E);

        load_a(8'h12); load_t(8'h34); issue(5'h12);
        check("mul_busy0", 16'(busy), 16'h1);
        check("mul_out_held", 16'(out), 16'h12);
        wait_busy(n);
        check("mul_busy_cycles", 16'(n), 16'd8);
        check("mul_done", 16'(done), 16'h1);
        check("mul_out", 16'(out), 16'hA8);
        check("mul_hi", 16'(hi), 16'h03);
        check("mul_flags", 16'(flags), 16'h12);
        tick();
        check("mul_done_fall", 16'(done), 16'h0);

        load_a(8'd200); load_t(8'd7); issue(5'h13);
`ifdef ALU_SEQ_DIV_EN
        wait_busy(n);
        check("div_busy_cycles", 16'(n), 16'd8);
        check("div_done", 16'(done), 16'h1);
        check("div_out", 16'(out), 16'h1C);
        check("div_hi", 16'(hi), 16'h04);
        check("div_flags", 16'(flags), 16'h00);
        tick();
        check("div_done_fall", 16'(done), 16'h0);
        load_t(8'h00); issue(5'h13);
        check("div0_busy", 16'(busy), 16'h0);
        check("div0_done", 16'(done), 16'h1);
        check("div0_flags", 16'(flags), 16'h22);
        check("div0_out", 16'(out), 16'h1C);
        check("div0_hi", 16'(hi), 16'h04);
        tick();
        check("div0_done_fall", 16'(done), 16'h0);
`else
        check("nodiv_busy", 16'(busy), 16'h0);
        check("nodiv_done", 16'(done), 16'h0);
        check("nodiv_out", 16'(out), 16'hC8);
        check("nodiv_hi", 16'(hi), 16'h03);
        check("nodiv_flags", 16'(flags), 16'h12);
        tick();
        check("nodiv_done_later", 16'(done | busy), 16'h0);
`endif

        load_a(8'h12); load_t(8'h34); issue(5'h12);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_run_out", 16'(out), 16'h00);
        check("rst_run_hi", 16'(hi), 16'h00);
        check("rst_run_flags", 16'(flags), 16'h00);
        check("rst_run_busy", 16'(busy), 16'h0);
        #2 rst_n = 1'b1;
        tick();
        check("rst_idle_busy", 16'(busy | done), 16'h0);
        load_a(8'h02); load_t(8'h03); issue(5'h00);
        check("post_rst_add_out", 16'(out), 16'h05);
        check("post_rst_add_flags", 16'(flags), 16'h04);

        load_a(8'h81); issue(5'h08);
        check("rlc_out", 16'(out), 16'h03);
        check("rlc_flags", 16'(flags), 16'h06);
        issue(5'h0B);
        check("rar_out", 16'(out), 16'h81);
        check("rar_flags", 16'(flags), 16'h06);
        issue(5'h0F);
        check("cmc_flags", 16'(flags), 16'h04);

        load_a(8'h7F); issue(5'h10);
        check("inr_ovf_out", 16'(out), 16'h80);
        check("inr_ovf_flags", 16'(flags), 16'h18);

        flags_we = 1'b1; bus = 8'hFF;
        tick();
        flags_we = 1'b0;
        check("flags_load", 16'(flags), 16'(8'h1F | E_BIT));

        cs = 1'b1; op = 5'h10;
        tick();
        check("held_cs_1", 16'(out), 16'h81);
        tick();
        cs = 1'b0;
        check("held_cs_2", 16'(out), 16'h82);
        check("held_cs_flags", 16'(flags), 16'(8'h0E | E_BIT));

        a_store = 1'b1;
        tick();
        a_store = 1'b0;
        load_a(8'h55);
        check("store_then_load", 16'(out), 16'h55);
        a_restore = 1'b1;
        tick();
        a_restore = 1'b0;
        check("restore", 16'(out), 16'h82);

        a_we = 1'b1; bus = 8'h11; cs = 1'b1; op = 5'h0D;
        tick();
        a_we = 1'b0; cs = 1'b0;
        check("a_we_over_cs", 16'(out), 16'h11);
        issue(5'h0D);
        check("cma_out", 16'(out), 16'hEE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
